// File: rtl/lc3_mem_responder_pkg.sv
// Shared LC3 definitions: responder state encoding, word width and the
// opcode values the control unit decodes.
package lc3_pkg;

   localparam int LC3_WORD = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_WAIT   = 2'b01,
      ST_ACCESS = 2'b10,
      ST_RESP   = 2'b11
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_EXT = 4'b1101;

endpackage

// File: rtl/lc3_mem_responder_sram.sv
// Single-port synchronous RAM with registered read data; a write returns
// the newly written word on the same edge.
module lc3_sram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [DATA_WIDTH-1:0] WDATA,
   output logic [DATA_WIDTH-1:0] RDATA
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge CLK) begin
      if (WE) begin
         mem[ADDR] <= WDATA;
         RDATA     <= WDATA;
      end else begin
         RDATA     <= mem[ADDR];
      end
   end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory responder for LC3 control-unit accesses: latches a request, waits
// WAIT_STATES cycles, performs one RAM access and pulses MEM_READY.
module lc3_mem_responder
   import lc3_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  MAR_LE,
   input  logic [LC3_WORD-1:0]   MAR_IN,
   input  logic                  MEM_REQ,
   input  logic                  MEM_WE,
   input  logic [DATA_WIDTH-1:0] MEM_WDATA,
   output logic [DATA_WIDTH-1:0] MEM_RDATA,
   output logic                  MEM_READY,
   output logic                  MEM_BUSY
);

   localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  accept;
   logic [LC3_WORD-1:0]   mar;
   logic [LC3_WORD-1:0]   addr_lat;
   logic                  we_lat;
   logic [DATA_WIDTH-1:0] wdata_lat;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] rdata_hold;
   logic                  ready;
   logic                  ram_we;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         mar        <= '0;
         ready      <= 1'b0;
         rdata_hold <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ready <= (state == ST_ACCESS);
         if (MAR_LE) begin
            mar <= MAR_IN;
         end
         if (state == ST_RESP) begin
            rdata_hold <= ram_rdata;
         end
      end
   end

   // A MAR load on the accepting edge supplies the access address directly.
   always_ff @(posedge CLK) begin
      if (accept) begin
         addr_lat  <= MAR_LE ? MAR_IN : mar;
         we_lat    <= MEM_WE;
         wdata_lat <= MEM_WDATA;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (MEM_REQ) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nxt = ST_ACCESS;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = ST_ACCESS;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ST_ACCESS: state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // RAM is outside reset so a write issued on the ACCESS edge always lands.
   assign ram_we = (state == ST_ACCESS) && we_lat;

   lc3_sram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sram (
      .CLK   (CLK),
      .WE    (ram_we),
      .ADDR  (addr_lat[ADDR_WIDTH-1:0]),
      .WDATA (wdata_lat),
      .RDATA (ram_rdata)
   );

   // Upper address bits alias onto the RAM and are intentionally dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^{1'b0, addr_lat};

   assign MEM_RDATA = (state == ST_RESP) ? ram_rdata : rdata_hold;
   assign MEM_READY = ready;
   assign MEM_BUSY  = (state != ST_IDLE);

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0
// instance, with expected read data queued at request time.
module tb_lc3_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        rst2 = 1'b0, le2 = 1'b0, req2 = 1'b0, we2 = 1'b0;
   logic [15:0] mar2 = '0, wd2 = '0, rd2;
   logic        rdy2, busy2;
   logic        rst0 = 1'b0, le0 = 1'b0, req0 = 1'b0, we0 = 1'b0;
   logic [15:0] mar0 = '0, wd0 = '0, rd0;
   logic        rdy0, busy0;

   logic [15:0] exp_q2[$];
   logic [15:0] exp_q0[$];

   lc3_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(2)) dut2 (
      .CLK(clk), .RESET(rst2), .MAR_LE(le2), .MAR_IN(mar2), .MEM_REQ(req2),
      .MEM_WE(we2), .MEM_WDATA(wd2), .MEM_RDATA(rd2), .MEM_READY(rdy2), .MEM_BUSY(busy2)
   );

   lc3_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0)) dut0 (
      .CLK(clk), .RESET(rst0), .MAR_LE(le0), .MAR_IN(mar0), .MEM_REQ(req0),
      .MEM_WE(we0), .MEM_WDATA(wd0), .MEM_RDATA(rd0), .MEM_READY(rdy0), .MEM_BUSY(busy0)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Returns #1 after the accepting edge.
   task automatic issue2(input logic load, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd);
      @(posedge clk); #1;
      le2 = load; mar2 = addr; req2 = 1'b1; we2 = we; wd2 = wd;
      @(posedge clk); #1;
      le2 = 1'b0; req2 = 1'b0;
   endtask

   task automatic wait_resp2(input string name, input int exp_lat);
      int k = 0;
      bit seen = 1'b0;
      logic [15:0] exp;
      while (!seen && k < 20) begin
         @(negedge clk);
         k++;
         if (rdy2) seen = 1'b1;
      end
      exp = (exp_q2.size() > 0) ? exp_q2.pop_front() : 16'h0000;
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s_ready: no ready within 20 cycles, required one", name);
      end else begin
         total++;
         if (k - 1 !== exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, k - 1, exp_lat);
         end
         total++;
         if (rd2 !== exp) begin
            bad++;
            $display("FAIL %s_rdata: got %h, required %h", name, rd2, exp);
         end
         @(negedge clk);
         total++;
         if (rdy2 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: ready=%b busy=%b, required 0 0", name, rdy2, busy2);
         end
      end
   endtask

   task automatic test_reset;
      rst2 = 1'b1; rst0 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // Request on the same edge as reset must be dropped.
      req2 = 1'b1; le2 = 1'b1; mar2 = 16'h0005;
      @(posedge clk); #1;
      rst2 = 1'b0; rst0 = 1'b0; req2 = 1'b0; le2 = 1'b0;
      @(negedge clk);
      total++;
      if ({busy2, rdy2, rd2} !== 18'd0) begin
         bad++;
         $display("FAIL reset_ws2: busy=%b ready=%b rdata=%h, required 0 0 0000", busy2, rdy2, rd2);
      end
      total++;
      if ({busy0, rdy0, rd0} !== 18'd0) begin
         bad++;
         $display("FAIL reset_ws0: busy=%b ready=%b rdata=%h, required 0 0 0000", busy0, rdy0, rd0);
      end
   endtask

   task automatic test_write_read;
      issue2(1'b1, 1'b1, 16'h0005, 16'h1234);
      exp_q2.push_back(16'h1234);
      wait_resp2("wr_write", 3);
      issue2(1'b1, 1'b0, 16'h0005, 16'h0000);
      exp_q2.push_back(16'h1234);
      wait_resp2("wr_read", 3);
   endtask

   task automatic test_zero_wait;
      logic        acc_we [2] = '{1'b1, 1'b0};
      logic [15:0] acc_wd [2] = '{16'hBEEF, 16'h0000};
      for (int i = 0; i < 2; i++) begin
         int busyc = 0;
         int readyc = 0;
         int lat = -1;
         @(posedge clk); #1;
         le0 = 1'b1; mar0 = 16'h0040; req0 = 1'b1; we0 = acc_we[i]; wd0 = acc_wd[i];
         @(posedge clk); #1;
         le0 = 1'b0; req0 = 1'b0;
         exp_q0.push_back(16'hBEEF);
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (busy0) busyc++;
            if (rdy0) begin
               logic [15:0] exp;
               readyc++;
               lat = k - 1;
               exp = exp_q0.pop_front();
               total++;
               if (rd0 !== exp) begin
                  bad++;
                  $display("FAIL zw_rdata[%0d]: got %h, required %h", i, rd0, exp);
               end
            end
         end
         total++;
         if (readyc !== 1 || lat !== 1) begin
            bad++;
            $display("FAIL zw_ready[%0d]: pulses=%0d latency=%0d, required 1 1", i, readyc, lat);
         end
         total++;
         if (busyc !== 2) begin
            bad++;
            $display("FAIL zw_busy[%0d]: busy cycles=%0d, required 2", i, busyc);
         end
      end
   endtask

   task automatic test_busy_ignore;
      logic [11:0] mask = '0;
      @(posedge clk); #1;
      le2 = 1'b1; mar2 = 16'h0005; we2 = 1'b0; req2 = 1'b1;
      exp_q2.push_back(16'h1234);
      exp_q2.push_back(16'h1234);
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (n == 0) le2 = 1'b0;
         if (n == 9) req2 = 1'b0;
         @(negedge clk);
         if (rdy2) begin
            logic [15:0] exp;
            mask[n] = 1'b1;
            exp = (exp_q2.size() > 0) ? exp_q2.pop_front() : 16'h0000;
            total++;
            if (rd2 !== exp) begin
               bad++;
               $display("FAIL busy_rdata[%0d]: got %h, required %h", n, rd2, exp);
            end
         end
      end
      total++;
      if (mask !== 12'h108) begin
         bad++;
         $display("FAIL busy_ready_cycles: got mask %h, required 108", mask);
      end
      total++;
      if (busy2 !== 1'b0) begin
         bad++;
         $display("FAIL busy_idle_after: busy=%b, required 0", busy2);
      end
      exp_q2.delete();
   endtask

   task automatic test_mar_inflight;
      issue2(1'b1, 1'b1, 16'h0010, 16'h00AA);
      exp_q2.push_back(16'h00AA);
      wait_resp2("mar_pre10", 3);
      issue2(1'b1, 1'b1, 16'h0020, 16'h0BB0);
      exp_q2.push_back(16'h0BB0);
      wait_resp2("mar_pre20", 3);
      issue2(1'b1, 1'b0, 16'h0010, 16'h0000);
      exp_q2.push_back(16'h00AA);
      le2 = 1'b1; mar2 = 16'h0020;
      @(posedge clk); #1;
      le2 = 1'b0;
      wait_resp2("mar_inflight", 2);
      issue2(1'b0, 1'b0, 16'hFFFF, 16'h0000);
      exp_q2.push_back(16'h0BB0);
      wait_resp2("mar_next", 3);
   endtask

   task automatic test_alias;
      issue2(1'b1, 1'b1, 16'h0105, 16'h5A5A);
      exp_q2.push_back(16'h5A5A);
      wait_resp2("alias_write", 3);
      issue2(1'b1, 1'b0, 16'h0005, 16'h0000);
      exp_q2.push_back(16'h5A5A);
      wait_resp2("alias_read", 3);
   endtask

   task automatic test_reset_midop;
      int stray = 0;
      issue2(1'b1, 1'b1, 16'h0003, 16'h0001);
      exp_q2.push_back(16'h0001);
      wait_resp2("rst_pre", 3);
      issue2(1'b1, 1'b1, 16'h0003, 16'hFFFF);
      rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      @(negedge clk);
      total++;
      if ({busy2, rdy2, rd2} !== 18'd0) begin
         bad++;
         $display("FAIL rst_midop: busy=%b ready=%b rdata=%h, required 0 0 0000", busy2, rdy2, rd2);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (rdy2 || busy2) stray++;
      end
      total++;
      if (stray !== 0) begin
         bad++;
         $display("FAIL rst_quiet: %0d active cycles after reset, required 0", stray);
      end
      issue2(1'b1, 1'b0, 16'h0003, 16'h0000);
      exp_q2.push_back(16'h0001);
      wait_resp2("rst_readback", 3);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero_wait();
      test_busy_ignore();
      test_mar_inflight();
      test_alias();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
